// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera front-end pipeline.
package cam_pkg;

    localparam int unsigned PIX_W          = 8;
    localparam int unsigned DEF_IMG_WIDTH  = 320;
    localparam int unsigned DEF_IMG_HEIGHT = 240;
    localparam int unsigned DEF_ADDR_W     = 17;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        FILL       = 2'd1,
        RUN        = 2'd2
    } state_t;

endpackage

// File: rtl/line_ram_8b.sv
// Simple dual-port line memory: read-before-write, registered read data.
module line_ram_8b
    import cam_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_IMG_WIDTH,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data only moves on a read, so it holds between accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/gray8_line_buffer_3x3.sv
// Two-line buffer feeding the Sobel stage: emits a vertical 3-pixel column per accepted
// pixel with position, border and malformed-line tracking.
module gray8_line_buffer_3x3
    import cam_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic              pixel_valid,
    input  logic              vsync,
    input  logic              active_area,
    output logic [PIX_W-1:0]  col_top,
    output logic [PIX_W-1:0]  col_mid,
    output logic [PIX_W-1:0]  col_bot,
    output logic              col_valid,
    output logic              rows_ready,
    output logic              border,
    output logic [ADDR_W-1:0] pixel_addr_out,
    output logic              line_overrun
);

    localparam int unsigned XW  = $clog2(IMG_WIDTH + 1);
    localparam int unsigned YW  = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned RAW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [XW-1:0]     X_END    = XW'(IMG_WIDTH);
    localparam logic [XW-1:0]     X_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0]     Y_READY  = YW'(2);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state, state_nx;
    logic              vsync_q, active_q;
    logic [XW-1:0]     x, x_eff, x_nx;
    logic [YW-1:0]     y, y_eff;
    logic [ADDR_W-1:0] addr_cnt, addr_eff, addr_nx;
    logic              frame_start, line_start, new_line, in_frame;
    logic              arrive, accept, drop;
    logic              overrun_nx, border_nx, ready_nx;
    logic [RAW-1:0]    rd_col, wr_col;

    // Position bookkeeping and next-state; frame start wins over line start.
    always_comb begin
        frame_start = vsync & ~vsync_q;
        line_start  = active_area & ~active_q;
        in_frame    = frame_start | (state != WAIT_FRAME);
        new_line    = line_start & ~frame_start & (state != WAIT_FRAME) & (x != '0);
        x_eff       = x;
        y_eff       = y;
        addr_eff    = addr_cnt;
        state_nx    = state;

        if (frame_start) begin
            x_eff    = '0;
            y_eff    = '0;
            addr_eff = '0;
        end else if (new_line) begin
            x_eff = '0;
            y_eff = y + YW'(1);
        end

        arrive     = enable & pixel_valid & active_area & in_frame;
        accept     = arrive & (x_eff < X_END);
        drop       = arrive & (x_eff == X_END);
        border_nx  = (x_eff == '0) | (x_eff == X_LAST) | (y_eff < Y_READY) | (y_eff == Y_LAST);
        ready_nx   = (y_eff >= Y_READY);
        x_nx       = accept ? x_eff + XW'(1) : x_eff;
        addr_nx    = (accept && (addr_eff != ADDR_MAX)) ? addr_eff + ADDR_W'(1) : addr_eff;
        overrun_nx = (line_overrun & ~frame_start) | drop;
        rd_col     = RAW'(x_eff);

        if (frame_start) begin
            state_nx = FILL;
        end else begin
            case (state)
                FILL: if (new_line && (y_eff == Y_READY)) state_nx = RUN;
                RUN:  if (accept && (y_eff == Y_LAST) && (x_eff == X_LAST)) state_nx = WAIT_FRAME;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WAIT_FRAME;
            vsync_q        <= 1'b0;
            active_q       <= 1'b0;
            x              <= '0;
            y              <= '0;
            addr_cnt       <= '0;
            col_bot        <= '0;
            col_valid      <= 1'b0;
            rows_ready     <= 1'b0;
            border         <= 1'b0;
            pixel_addr_out <= '0;
            line_overrun   <= 1'b0;
            wr_col         <= '0;
        end else begin
            state        <= state_nx;
            vsync_q      <= vsync;
            active_q     <= active_area;
            x            <= x_nx;
            y            <= y_eff;
            addr_cnt     <= addr_nx;
            col_valid    <= accept;
            line_overrun <= overrun_nx;
            if (accept) begin
                col_bot        <= pixel_in;
                pixel_addr_out <= addr_eff;
                border         <= border_nx;
                rows_ready     <= ready_nx;
                wr_col         <= RAW'(x_eff);
            end
        end
    end

    // A holds line y-1; the line it loses drops into B one cycle later, when its read data lands.
    line_ram_8b #(.DEPTH(IMG_WIDTH), .AW(RAW)) u_ram_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_addr (rd_col),
        .wr_data (pixel_in),
        .rd_en   (accept),
        .rd_addr (rd_col),
        .rd_data (col_mid)
    );

    line_ram_8b #(.DEPTH(IMG_WIDTH), .AW(RAW)) u_ram_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (col_valid),
        .wr_addr (wr_col),
        .wr_data (col_mid),
        .rd_en   (accept),
        .rd_addr (rd_col),
        .rd_data (col_top)
    );

endmodule

// File: doc/gray8_line_buffer_3x3.md
Name: gray8_line_buffer_3x3

Overview:
- Upstream stage of the 3x3 Sobel filter.
- Accepts an 8-bit grayscale raster stream and stores the two previous lines in on-chip RAM.
- Per input pixel, emits a vertically aligned 3-pixel column (rows y-2, y-1, y) with valid and border flags. The Sobel stage only has to shift columns horizontally.
- Also tracks frame, line and pixel position and flags malformed lines.

Parameters:
- IMG_WIDTH, 320, pixels per line; sets line RAM depth.
- IMG_HEIGHT, 240, lines per frame.
- ADDR_W, 17, width of pixel_addr_out; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.

Ports:
- clk  in  1  single pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; when 0 nothing is written and outputs go invalid.
- pixel_in  in  8  grayscale sample.
- pixel_valid  in  1  pixel_in is valid this cycle.
- vsync  in  1  frame sync; rising edge starts a frame.
- active_area  in  1  high during active pixels of a line.
- col_top  out  8  pixel (x, y-2).
- col_mid  out  8  pixel (x, y-1).
- col_bot  out  8  pixel (x, y), the delayed input.
- col_valid  out  1  column outputs valid this cycle.
- rows_ready  out  1  y >= 2, so all three rows hold real frame data.
- border  out  1  x==0, x==IMG_WIDTH-1, y<2 or y==IMG_HEIGHT-1.
- pixel_addr_out  out  ADDR_W  y*IMG_WIDTH + x of col_bot.
- line_overrun  out  1  sticky per frame: more than IMG_WIDTH pixels arrived in one line.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0;
  - x = y = 0;
  - state = WAIT_FRAME;
  - the edge-detect registers for vsync and active_area are cleared.
  - Line RAM contents are not cleared.
- Edge detection: vsync and active_area are registered once. Frame start = vsync & ~vsync_q. Line start = active_area & ~active_q.
- Accepted pixel: accept = enable & pixel_valid & active_area & (state != WAIT_FRAME) & (x < IMG_WIDTH).
- States:
  - WAIT_FRAME → FILL on frame start.
  - FILL: y < 2. Columns are emitted with rows_ready = 0.
  - FILL → RUN on the line start that makes y == 2.
  - RUN → WAIT_FRAME after the last accepted pixel of line IMG_HEIGHT-1.
  - Any state → FILL on frame start; a mid-frame vsync restarts the frame with x = y = 0 and clears line_overrun.
- Counters:
  - x increments on accept.
  - On line start, if x != 0: y increments and x = 0.
  - Frame start has priority over a simultaneous line start.
- Line RAMs: two single-clock memories A and B, IMG_WIDTH x 8 each. On accept at column x:
  - read A[x] and B[x];
  - write A[x] <= pixel_in and B[x] <= old A[x] (read-before-write, same cycle).
- Output latency is exactly 1 cycle after accept:
  - col_top = old B[x];
  - col_mid = old A[x];
  - col_bot = registered pixel_in;
  - col_valid = registered accept;
  - pixel_addr_out, border and rows_ready are registered alongside.
- When col_valid = 0, col_* and pixel_addr_out hold their previous values.
- Overrun: a pixel arriving with x == IMG_WIDTH is dropped and sets line_overrun, which stays set until the next frame start or reset.
- A short line (fewer than IMG_WIDTH pixels) is not flagged. Unwritten RAM columns keep stale data.
- enable = 0 mid-line: pixels are dropped, x does not advance, col_valid = 0.
- pixel_addr_out arithmetic: computed incrementally (+1 per accept, reset to 0 on frame start). No multiplier. Saturates at 2^ADDR_W-1.
- vsync and active_area rising in the same cycle: the frame-start action is taken. The first pixel of that cycle is accepted as x = 0, y = 0.

Decomposition:
- Shared package cam_pkg:
  - PIX_W = 8;
  - IMG_WIDTH/IMG_HEIGHT defaults;
  - ADDR_W;
  - the state enum (WAIT_FRAME, FILL, RUN).
- One sub-module: line_ram_8b, a simple dual-port, read-before-write, 1-cycle-read memory. It is instantiated twice (A and B).

Test Plan:
- Reset with pixel_valid high → all outputs 0, col_valid stays 0 until the first frame start.
- Frame of 4x4 (IMG_WIDTH=4, IMG_HEIGHT=4) with pixel value = 16*y + x → on line 2, col x=1: col_top=0x01, col_mid=0x11, col_bot=0x21; rows_ready=1; border=0; pixel_addr_out=9.
- Line 0 of the same frame → col_valid=1, rows_ready=0, border=1 on every column; col_bot equals the input delayed 1 cycle.
- Send 6 pixels in a 4-wide line → 4 columns valid; line_overrun=1 from the 5th pixel and held until the next vsync rise, where it returns to 0.
- Drop enable for 2 cycles mid-line 2 → no col_valid in those cycles, x is not advanced; the next column resumes at the correct x with correct col_top/col_mid.
- Assert rst_n=0 mid-frame, then release and vsync rise → counters restart at 0, state FILL, first column has pixel_addr_out=0, rows_ready=0.
